// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared widths and constants for the instruction prefetch queue.
// Address and instruction widths track the core's instruction-address type.
package fetch_prefetch_buffer_pkg;

  localparam int INSN_ADDR_W  = 32;
  localparam int INSN_DATA_W  = 32;
  localparam int FETCH_DEPTH  = 4;
  localparam int WORD_BYTES   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction FIFO with flush; pointers wrap modulo DEPTH.
// Storage is cleared on reset so the head reads zero before the first push.
module fetch_fifo
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int W     = INSN_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetch queue between instruction memory and IF: issues sequential fetches
// under a credit limit and drops wrong-path responses after a redirect.
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int                ADDR_W   = INSN_ADDR_W,
  parameter int                INSN_W   = INSN_DATA_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_address,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [INSN_W-1:0] resp_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(WORD_BYTES - 1);

  logic [ADDR_W-1:0] fetch_pc, head_pc;
  logic [CNT_W-1:0]  count, outstanding, discard;
  logic [CNT_W-1:0]  outstanding_n, discard_n;
  logic              started;
  logic              accept, push, pop;
  logic [ADDR_W-1:0] jump_target;

  assign jump_target = jump_address & ALIGN;

  // Credits cover both queued entries and in-flight requests, so a push never overflows.
  assign req_valid  = started && !jump_enable &&
                      (({1'b0, count} + {1'b0, outstanding}) < DEPTH_SUM);
  assign req_addr   = fetch_pc;
  assign accept     = req_valid && req_ready;

  assign insn_valid = (count != '0);
  assign pc         = head_pc;
  assign pop        = insn_valid && insn_ready && !jump_enable;
  assign push       = resp_valid && !jump_enable && (discard == '0);

  always_comb begin
    outstanding_n = outstanding;
    if (accept && !resp_valid)      outstanding_n = outstanding + CNT_ONE;
    else if (!accept && resp_valid) outstanding_n = outstanding - CNT_ONE;
  end

  // A response landing in the redirect cycle is already dropped, so it is not counted again.
  always_comb begin
    discard_n = discard;
    if (jump_enable)                      discard_n = resp_valid ? outstanding - CNT_ONE : outstanding;
    else if (resp_valid && discard != '0) discard_n = discard - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      if (jump_enable) begin
        fetch_pc <= jump_target;
        head_pc  <= jump_target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + STEP;
        if (pop)    head_pc  <= head_pc + STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSN_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (resp_data),
    .pop       (pop),
    .flush     (jump_enable),
    .count     (count),
    .head      (insn)
  );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for the prefetch queue with an in-order fixed-latency memory
// model; mem[addr] = 0x1000 + addr/4.
module tb_fetch_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_enable;
  logic [31:0] jump_address;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  logic [31:0] pq_addr[$];
  int          pq_due[$];

  always #5 clk = ~clk;

  fetch_prefetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .jump_enable  (jump_enable),
    .jump_address (jump_address),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn         (insn),
    .pc           (pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive any due response, record an accepted request, advance to next negedge.
  task automatic tick();
    resp_valid = 1'b0;
    resp_data  = '0;
    if (pq_addr.size() > 0 && pq_due[0] == cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(pq_addr[0]);
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    #1;
    if (!rst && req_valid && req_ready) begin
      pq_addr.push_back(req_addr);
      pq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_enable = 1'b0;
    resp_valid = 1'b0;
    pq_addr.delete();
    pq_due.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; jump_enable = 1'b0; jump_address = '0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0; insn_ready = 1'b1;

    // Reset held three cycles
    tick(); tick(); tick();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_insn_valid", {31'b0, insn_valid}, 32'd0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_pc", pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req_valid_pre_clk", {31'b0, req_valid}, 32'd0);
    tick();
    chk("first_req_valid", {31'b0, req_valid}, 32'd1);
    chk("first_req_addr", req_addr, 32'h0);

    // Streaming with L=1: first instruction two cycles after its request
    tick();
    chk("stream_no_insn_yet", {31'b0, insn_valid}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stream_valid", {31'b0, insn_valid}, 32'd1);
      chk("stream_insn", insn, 32'h1000 + i);
      chk("stream_pc", pc, 32'(4 * i));
      chk("stream_req_addr", req_addr, 32'(8 + 4 * i));
      tick();
    end

    // Stall: four credits fill, then requests stop
    do_reset();
    insn_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", {31'b0, req_valid}, 32'd1);
      chk("stall_req_addr", req_addr, 32'(4 * i));
      tick();
    end
    chk("stall_credit_out", {31'b0, req_valid}, 32'd0);
    tick();
    chk("stall_full_no_req", {31'b0, req_valid}, 32'd0);
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, insn_valid}, 32'd1);
      chk("drain_insn", insn, 32'h1000 + i);
      chk("drain_pc", pc, 32'(4 * i));
      if (i == 1) chk("resume_req_addr", req_addr, 32'h10);
      tick();
    end
    chk("resume_insn", insn, 32'h1004);
    chk("resume_pc", pc, 32'h10);

    // Redirect with two requests in flight at L=3
    do_reset();
    lat = 3;
    tick();
    tick();
    jump_enable = 1'b1; jump_address = 32'h100;
    #1;
    chk("jmp_no_req", {31'b0, req_valid}, 32'd0);
    tick();
    jump_enable = 1'b0;
    #1;
    chk("jmp_req_valid", {31'b0, req_valid}, 32'd1);
    chk("jmp_req_addr", req_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      chk("jmp_drop_valid", {31'b0, insn_valid}, 32'd0);
      tick();
    end
    chk("jmp_target_valid", {31'b0, insn_valid}, 32'd1);
    chk("jmp_target_pc", pc, 32'h100);
    chk("jmp_target_insn", insn, 32'h1040);

    // Redirect coincident with a response and a queued head; misaligned target
    do_reset();
    lat = 1;
    tick();
    tick();
    chk("coin_head_valid", {31'b0, insn_valid}, 32'd1);
    jump_enable = 1'b1; jump_address = 32'h203;
    tick();
    jump_enable = 1'b0;
    #1;
    chk("coin_flushed", {31'b0, insn_valid}, 32'd0);
    chk("coin_pc", pc, 32'h200);
    chk("coin_req_addr", req_addr, 32'h200);
    tick();
    chk("coin_still_empty", {31'b0, insn_valid}, 32'd0);
    tick();
    chk("coin_new_valid", {31'b0, insn_valid}, 32'd1);
    chk("coin_new_pc", pc, 32'h200);
    chk("coin_new_insn", insn, 32'h1080);

    // Memory backpressure then asynchronous reset mid-stream
    do_reset();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", {31'b0, req_valid}, 32'd1);
      chk("bp_req_addr", req_addr, 32'h0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    tick();
    chk("bp_insn_valid", {31'b0, insn_valid}, 32'd1);
    chk("bp_insn", insn, 32'h1000);
    #2;
    rst = 1'b1;
    #1;
    chk("async_insn_valid", {31'b0, insn_valid}, 32'd0);
    chk("async_req_valid", {31'b0, req_valid}, 32'd0);
    chk("async_pc", pc, 32'h0);
    do_reset();
    chk("restart_req_valid", {31'b0, req_valid}, 32'd1);
    chk("restart_req_addr", req_addr, 32'h0);
    tick();
    tick();
    chk("restart_insn", insn, 32'h1000);
    chk("restart_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
